// File: rtl/noc_router_xy.sv
// Five-port XY mesh router: a circular input FIFO per port, a round-robin
// arbiter per output port, and one output register per output port.
module noc_router_xy #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 5,
    parameter int unsigned MESH_COLS     = 4,
    parameter int unsigned MESH_ROWS     = 4,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned ID            = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [5*ADDRESS_WIDTH-1:0] in_addr,
    input  logic [5*DATA_WIDTH-1:0]    in_data,
    input  logic [4:0]                 in_valid,
    output logic [4:0]                 to_in_ack,
    output logic [5*ADDRESS_WIDTH-1:0] out_addr,
    output logic [5*DATA_WIDTH-1:0]    out_data,
    output logic [4:0]                 out_valid,
    input  logic [4:0]                 from_out_ack,
    output logic                       err_drop
);
    localparam int unsigned NP     = 5;
    localparam int unsigned AW     = ADDRESS_WIDTH;
    localparam int unsigned DW     = DATA_WIDTH;
    localparam int unsigned PTRW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNTW   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW     = 3;
    localparam int unsigned NODES  = MESH_ROWS * MESH_COLS;
    localparam int unsigned MY_ROW = ID / MESH_COLS;
    localparam int unsigned MY_COL = ID % MESH_COLS;

    localparam logic [PW-1:0] P_LOCAL = 3'd0;
    localparam logic [PW-1:0] P_WEST  = 3'd1;
    localparam logic [PW-1:0] P_NORTH = 3'd2;
    localparam logic [PW-1:0] P_EAST  = 3'd3;
    localparam logic [PW-1:0] P_SOUTH = 3'd4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } flit_t;

    flit_t           fifo_q       [NP][FIFO_DEPTH];
    flit_t           fifo_d       [NP][FIFO_DEPTH];
    logic [PTRW-1:0] wr_ptr_q     [NP];
    logic [PTRW-1:0] wr_ptr_d     [NP];
    logic [PTRW-1:0] rd_ptr_q     [NP];
    logic [PTRW-1:0] rd_ptr_d     [NP];
    logic [CNTW-1:0] count_q      [NP];
    logic [CNTW-1:0] count_d      [NP];
    flit_t           out_q        [NP];
    flit_t           out_d        [NP];
    logic [PW-1:0]   last_grant_q [NP];
    logic [PW-1:0]   last_grant_d [NP];
    logic [NP-1:0]   out_valid_q, out_valid_d;
    logic            err_drop_q, err_drop_d;

    flit_t           head         [NP];
    logic [PW-1:0]   head_route   [NP];
    logic [NP-1:0]   head_valid, head_illegal, granted, push, pop;

    // Head-of-line XY route decision; out-of-mesh addresses are flagged for dropping.
    always_comb begin : route_comb
        int unsigned dest, drow, dcol;
        dest = 0;
        drow = 0;
        dcol = 0;
        for (int p = 0; p < NP; p++) begin
            head[p]         = fifo_q[p][rd_ptr_q[p]];
            head_valid[p]   = (count_q[p] != '0);
            head_illegal[p] = 1'b0;
            head_route[p]   = P_LOCAL;
            dest = 32'(head[p].addr);
            drow = dest / MESH_COLS;
            dcol = dest % MESH_COLS;
            if (dest >= NODES) begin
                head_illegal[p] = 1'b1;
            end else if (dcol < MY_COL) begin
                head_route[p] = P_WEST;
            end else if (dcol > MY_COL) begin
                head_route[p] = P_EAST;
            end else if (drow < MY_ROW) begin
                head_route[p] = P_NORTH;
            end else if (drow > MY_ROW) begin
                head_route[p] = P_SOUTH;
            end
        end
    end

    // Per-output round-robin arbitration and output register load/drain.
    always_comb begin : arb_comb
        int unsigned idx;
        logic        found;
        idx     = 0;
        found   = 1'b0;
        granted = '0;
        for (int o = 0; o < NP; o++) begin
            out_d[o]        = out_q[o];
            out_valid_d[o]  = out_valid_q[o] & ~from_out_ack[o];
            last_grant_d[o] = last_grant_q[o];
            found           = 1'b0;
            if (!out_valid_q[o] || from_out_ack[o]) begin
                for (int unsigned k = 1; k <= NP; k++) begin
                    idx = (32'(last_grant_q[o]) + k) % NP;
                    if (!found && head_valid[idx] && !head_illegal[idx] &&
                        head_route[idx] == PW'(o)) begin
                        found           = 1'b1;
                        granted[idx]    = 1'b1;
                        out_d[o]        = head[idx];
                        out_valid_d[o]  = 1'b1;
                        last_grant_d[o] = PW'(idx);
                    end
                end
            end
        end
    end

    // Input FIFO push/pop bookkeeping.
    always_comb begin : fifo_comb
        fifo_d = fifo_q;
        for (int p = 0; p < NP; p++) begin
            push[p]     = in_valid[p] & (count_q[p] != CNTW'(FIFO_DEPTH));
            pop[p]      = granted[p] | (head_valid[p] & head_illegal[p]);
            wr_ptr_d[p] = wr_ptr_q[p];
            rd_ptr_d[p] = rd_ptr_q[p];
            if (push[p]) begin
                fifo_d[p][wr_ptr_q[p]] = {in_addr[p*AW +: AW], in_data[p*DW +: DW]};
                wr_ptr_d[p] = wr_ptr_q[p] + PTRW'(1);
            end
            if (pop[p]) begin
                rd_ptr_d[p] = rd_ptr_q[p] + PTRW'(1);
            end
            count_d[p] = count_q[p] + CNTW'(push[p]) - CNTW'(pop[p]);
        end
        err_drop_d = |(head_valid & head_illegal);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NP; p++) begin
                for (int e = 0; e < FIFO_DEPTH; e++) begin
                    fifo_q[p][e] <= '0;
                end
                wr_ptr_q[p]     <= '0;
                rd_ptr_q[p]     <= '0;
                count_q[p]      <= '0;
                out_q[p]        <= '0;
                last_grant_q[p] <= P_SOUTH;
            end
            out_valid_q <= '0;
            err_drop_q  <= 1'b0;
        end else begin
            fifo_q       <= fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            out_q        <= out_d;
            last_grant_q <= last_grant_d;
            out_valid_q  <= out_valid_d;
            err_drop_q   <= err_drop_d;
        end
    end

    // Output buses come straight from registered state.
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            to_in_ack[p]          = (count_q[p] != CNTW'(FIFO_DEPTH));
            out_addr[p*AW +: AW]  = out_q[p].addr;
            out_data[p*DW +: DW]  = out_q[p].data;
        end
        out_valid = out_valid_q;
        err_drop  = err_drop_q;
    end

endmodule

// File: tb/tb_noc_router_xy.sv
// Bench for noc_router_xy at node 5 of a 4x4 mesh: directed scenarios plus a
// randomized phase checked by a per-source in-order scoreboard.
module tb_noc_router_xy;
    localparam int unsigned DW     = 32;
    localparam int unsigned AW     = 5;
    localparam int          COLS   = 4;
    localparam int          ROWS   = 4;
    localparam int          MYID   = 5;
    localparam int          MY_ROW = MYID / COLS;
    localparam int          MY_COL = MYID % COLS;

    logic            clk;
    logic            rst;
    logic [5*AW-1:0] in_addr;
    logic [5*DW-1:0] in_data;
    logic [4:0]      in_valid;
    logic [4:0]      to_in_ack;
    logic [5*AW-1:0] out_addr;
    logic [5*DW-1:0] out_data;
    logic [4:0]      out_valid;
    logic [4:0]      from_out_ack;
    logic            err_drop;

    int n_checks;
    int n_errors;

    typedef struct {
        int            src;
        int            dst;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } sb_t;

    sb_t        pend[$];
    logic [4:0] last_acc;

    noc_router_xy #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MESH_COLS(COLS),
        .MESH_ROWS(ROWS), .FIFO_DEPTH(4), .ID(MYID)
    ) dut (
        .clk(clk), .rst(rst),
        .in_addr(in_addr), .in_data(in_data), .in_valid(in_valid),
        .to_in_ack(to_in_ack),
        .out_addr(out_addr), .out_data(out_data), .out_valid(out_valid),
        .from_out_ack(from_out_ack), .err_drop(err_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Destination port from the XY rule applied to node coordinates.
    function automatic int exp_port(int a);
        int r;
        int c;
        r = a / COLS;
        c = a % COLS;
        if (c < MY_COL) return 1;
        if (c > MY_COL) return 3;
        if (r < MY_ROW) return 2;
        if (r > MY_ROW) return 4;
        return 0;
    endfunction

    task automatic offer(input int p, input int a, input logic [DW-1:0] d);
        in_addr[p*AW +: AW] = AW'(a);
        in_data[p*DW +: DW] = d;
        in_valid[p]         = 1'b1;
    endtask

    task automatic sb_pop(input int o, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int hit;
        int first;
        hit   = -1;
        first = -1;
        for (int i = 0; i < pend.size(); i++)
            if (hit < 0 && pend[i].dst == o && pend[i].addr == a && pend[i].data == d) hit = i;
        chk($sformatf("sb_match_port%0d", o), 64'(hit >= 0), 64'(1));
        if (hit >= 0) begin
            for (int i = 0; i < pend.size(); i++)
                if (first < 0 && pend[i].dst == o && pend[i].src == pend[hit].src) first = i;
            chk("sb_order", 64'(first), 64'(hit));
            pend.delete(hit);
        end
    endtask

    // One clock edge: record transfers seen at the edge, update the scoreboard, check holds.
    task automatic step();
        logic [4:0]      acc, xfer, hold;
        logic [5*AW-1:0] ia, oa;
        logic [5*DW-1:0] id, od;
        acc  = in_valid & to_in_ack;
        xfer = out_valid & from_out_ack;
        hold = out_valid & ~from_out_ack;
        ia = in_addr; id = in_data; oa = out_addr; od = out_data;
        @(posedge clk);
        #1;
        last_acc = rst ? 5'b0 : acc;
        if (!rst) begin
            for (int o = 0; o < 5; o++)
                if (xfer[o]) sb_pop(o, oa[o*AW +: AW], od[o*DW +: DW]);
            for (int p = 0; p < 5; p++) begin
                if (acc[p] && int'(ia[p*AW +: AW]) < ROWS * COLS) begin
                    sb_t e;
                    e.src  = p;
                    e.dst  = exp_port(int'(ia[p*AW +: AW]));
                    e.addr = ia[p*AW +: AW];
                    e.data = id[p*DW +: DW];
                    pend.push_back(e);
                end
            end
            for (int o = 0; o < 5; o++) begin
                if (hold[o]) begin
                    chk("hold_valid", 64'(out_valid[o]), 64'(1));
                    chk("hold_addr", 64'(out_addr[o*AW +: AW]), 64'(oa[o*AW +: AW]));
                    chk("hold_data", 64'(out_data[o*DW +: DW]), 64'(od[o*DW +: DW]));
                end
            end
        end
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        last_acc     = '0;
        rst          = 1'b1;
        in_addr      = '0;
        in_data      = '0;
        in_valid     = '0;
        from_out_ack = '0;

        // Reset state, sampled between edges
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_to_in_ack", 64'(to_in_ack), 64'h1f);
        chk("rst_err_drop", 64'(err_drop), 64'(0));
        chk("rst_out_addr", 64'(out_addr), 64'(0));
        chk("rst_out_data_p3", 64'(out_data[3*DW +: DW]), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        chk("post_rst_ack", 64'(to_in_ack), 64'h1f);
        chk("post_rst_err", 64'(err_drop), 64'(0));

        // Local inject to node 7 (east), one-cycle latency
        from_out_ack = 5'h1f;
        offer(0, 7, 32'hDEADBEEF);
        step();
        in_valid = '0;
        chk("lat_not_yet", 64'(out_valid), 64'(0));
        step();
        chk("lat_valid", 64'(out_valid), 64'(5'b01000));
        chk("lat_addr", 64'(out_addr[3*AW +: AW]), 64'(7));
        chk("lat_data", 64'(out_data[3*DW +: DW]), 64'hDEADBEEF);
        repeat (2) step();

        // West and north both target this node; west wins first
        offer(1, 5, 32'h0000_00A1);
        offer(2, 5, 32'h0000_00B2);
        step();
        in_valid = '0;
        step();
        chk("cont_first_v", 64'(out_valid), 64'(5'b00001));
        chk("cont_first_d", 64'(out_data[0 +: DW]), 64'h00A1);
        step();
        chk("cont_second_v", 64'(out_valid), 64'(5'b00001));
        chk("cont_second_d", 64'(out_data[0 +: DW]), 64'h00B2);
        step();
        chk("cont_idle", 64'(out_valid), 64'(0));

        // Backpressure on east: five flits fit, the sixth is refused
        from_out_ack = 5'b10111;
        for (int i = 0; i < 6; i++) begin
            offer(0, 6, 32'(100 + i));
            chk($sformatf("bp_ack_%0d", i), 64'(to_in_ack[0]), 64'(i < 5));
            if (i < 5) step();
        end
        step();
        in_valid = '0;
        repeat (2) step();
        chk("bp_held_v", 64'(out_valid[3]), 64'(1));
        chk("bp_held_d", 64'(out_data[3*DW +: DW]), 64'(100));
        from_out_ack = 5'h1f;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_drain_v%0d", i), 64'(out_valid[3]), 64'(1));
            chk($sformatf("bp_drain_d%0d", i), 64'(out_data[3*DW +: DW]), 64'(100 + i));
            step();
        end
        chk("bp_empty", 64'(out_valid), 64'(0));

        // Out-of-mesh address on north input is dropped
        offer(2, 20, 32'h1234_5678);
        step();
        in_valid = '0;
        chk("ill_pre", 64'(err_drop), 64'(0));
        step();
        chk("ill_pulse", 64'(err_drop), 64'(1));
        chk("ill_no_out", 64'(out_valid), 64'(0));
        step();
        chk("ill_end", 64'(err_drop), 64'(0));
        chk("ill_no_out2", 64'(out_valid), 64'(0));
        chk("ill_fifo_ack", 64'(to_in_ack), 64'h1f);

        // Randomized traffic with random downstream backpressure
        for (int cyc = 0; cyc < 1500; cyc++) begin
            from_out_ack = 5'($urandom_range(0, 31)) | 5'($urandom_range(0, 31));
            for (int p = 0; p < 5; p++)
                if (!in_valid[p] && $urandom_range(0, 2) != 0)
                    offer(p, int'($urandom_range(0, 15)), $urandom);
            step();
            chk("rand_err_drop", 64'(err_drop), 64'(0));
            for (int p = 0; p < 5; p++)
                if (last_acc[p]) in_valid[p] = 1'b0;
        end
        in_valid     = '0;
        from_out_ack = 5'h1f;
        repeat (60) step();
        chk("rand_drained", 64'(pend.size()), 64'(0));
        chk("rand_idle", 64'(out_valid), 64'(0));

        // Reset with flits buffered
        from_out_ack = '0;
        offer(0, 7, 32'h0000_0111);
        offer(1, 6, 32'h0000_0222);
        offer(2, 4, 32'h0000_0333);
        step();
        in_valid = '0;
        step();
        chk("mid_buffered", 64'(out_valid != 0), 64'(1));
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_ack", 64'(to_in_ack), 64'h1f);
        pend.delete();
        step();
        step();
        rst          = 1'b0;
        from_out_ack = 5'h1f;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("mid_quiet", 64'(out_valid), 64'(0));
        end
        chk("mid_sb_empty", 64'(pend.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
